// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Issue/retire stage around a clocked ALU. Registers accepted
//             operations onto the ALU inputs and carries each tag through a
//             valid/tag pipe matching the ALU latency. Captures the result
//             into an output FIFO. Issue is credit-limited, so a capture
//             always finds a free FIFO slot.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue #(
    parameter int ALU_LAT   = 1,
    parameter int OUT_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [5:0]       in_func,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_operand_a,
    output logic [31:0]      alu_operand_b,
    output logic [5:0]       alu_func,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       inflight
);

    localparam int         c_ptr_w = $clog2(OUT_DEPTH);
    localparam int         c_cnt_w = c_ptr_w + 1;
    localparam logic [5:0] c_depth = 6'(OUT_DEPTH);

    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [5:0]       r_func;
    logic [ALU_LAT:0] r_pipe_vld;
    logic [TAG_W-1:0] r_pipe_tag [0:ALU_LAT];
    logic [2:0]       r_inflight;
    logic [c_cnt_w-1:0] r_fifo_count;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [31:0]      r_mem_result [0:OUT_DEPTH-1];
    logic [3:0]       r_mem_flags  [0:OUT_DEPTH-1];
    logic [TAG_W-1:0] r_mem_tag    [0:OUT_DEPTH-1];

    logic       w_accept;
    logic       w_capture;
    logic       w_pop;
    logic [5:0] w_credit_used;

    // Credits are spent by every entry either buffered or still in the ALU;
    // only registered state feeds in_ready.
    assign w_credit_used = 6'(r_fifo_count) + 6'(r_inflight);
    assign in_ready      = (w_credit_used < c_depth);
    assign w_accept      = in_valid && in_ready;
    assign w_capture     = r_pipe_vld[ALU_LAT];
    assign out_valid     = (r_fifo_count != '0);
    assign w_pop         = out_valid && out_ready;

    assign alu_operand_a = r_op_a;
    assign alu_operand_b = r_op_b;
    assign alu_func      = r_func;
    assign inflight      = r_inflight;

    assign out_result    = r_mem_result[r_rd_ptr];
    assign out_flags     = r_mem_flags[r_rd_ptr];
    assign out_tag       = r_mem_tag[r_rd_ptr];

    // ALU input registers load on accept and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_func <= '0;
        end else if (w_accept) begin
            r_op_a <= in_a;
            r_op_b <= in_b;
            r_func <= in_func;
        end
    end

    // Valid bits of the latency pipe; the last stage marks a result to capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[ALU_LAT-1:0], w_accept};
        end
    end

    // Tag shift alongside the valid bits; contents only matter where valid.
    always_ff @(posedge clk) begin
        r_pipe_tag[0] <= in_tag;
        for (int i = 1; i <= ALU_LAT; i++) begin
            r_pipe_tag[i] <= r_pipe_tag[i-1];
        end
    end

    // Operations inside the ALU: up on accept, down on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_capture})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // FIFO occupancy and pointers; full/empty derive from the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            case ({w_capture, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_cnt_w'(1);
                2'b01:   r_fifo_count <= r_fifo_count - c_cnt_w'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

    // FIFO storage write at the tail on capture; storage is not reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem_result[r_wr_ptr] <= alu_result;
            r_mem_flags[r_wr_ptr]  <= alu_flags;
            r_mem_tag[r_wr_ptr]    <= r_pipe_tag[ALU_LAT];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Self-checking bench for alu_issue with a one-cycle ALU model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue;

    localparam logic [5:0] c_func_add = 6'h20;
    localparam logic [5:0] c_func_sub = 6'h22;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [5:0]  in_func;
    logic [3:0]  in_tag;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [5:0]  alu_func;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  out_tag;
    logic [2:0]  inflight;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic rand_on = 1'b0;

    alu_issue #(.ALU_LAT(1), .OUT_DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_tag(in_tag),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_func(alu_func),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    // ALU model: flags are {negative, zero, carry, overflow}; sub carry = no borrow.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] f);
        logic [32:0] s;
        logic        v;
        case (f)
            c_func_add: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            c_func_sub: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                v = (a[31] != b[31]) && (s[31] != a[31]);
            end
            default: begin
                s = '0;
                v = 1'b0;
            end
        endcase
        return {s[31], (s[31:0] == 32'd0), s[32], v, s[31:0]};
    endfunction

    // One-cycle clocked ALU.
    always_ff @(posedge clk) begin
        {alu_flags, alu_result} <= alu_model(alu_operand_a, alu_operand_b, alu_func);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one operation until accepted; returns 1ns after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                         input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef);
        bit done = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_func = f; in_tag = tag;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{res: er, flg: ef, tag: tag});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            fails++;
            tests++;
            $display("FAIL issue_timeout: tag %0d never accepted", tag);
        end
        in_valid = 1'b0;
    endtask

    // Let everything outstanding retire with out_ready held high.
    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 100 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("drain_left", 64'(sb.size()), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
    endtask

    // Monitor: scoreboard compare on every pop, credit and inflight checks each cycle.
    initial begin : monitor
        logic       acc_now;
        logic [1:0] hist;
        exp_t       e;
        hist = '0;
        forever begin
            @(negedge clk);
            acc_now = !rst && in_valid && in_ready;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: result %0d tag %0d, none expected",
                             out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    check("out_result", 64'(out_result), 64'(e.res));
                    check("out_flags",  64'(out_flags),  64'(e.flg));
                    check("out_tag",    64'(out_tag),    64'(e.tag));
                end
            end
            @(posedge clk); #2;
            if (rst) begin
                hist = '0;
            end else begin
                hist = {hist[0], acc_now};
                check("inflight_track", 64'(inflight), 64'(hist[0]) + 64'(hist[1]));
                check("credit_rule", 64'(in_ready), 64'(sb.size() < 4));
                check("credit_bound", 64'(sb.size() <= 4), 64'd1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int accepts;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_func = '0; in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_inflight",  64'(inflight),  64'd0);
        check("reset_opa",       64'(alu_operand_a), 64'd0);
        check("reset_func",      64'(alu_func),  64'd0);

        // Single add: latency and register loading.
        issue(32'd100, 32'd75, c_func_add, 4'd3, 32'd175, 4'b0000);
        check("single_opa",  64'(alu_operand_a), 64'd100);
        check("single_opb",  64'(alu_operand_b), 64'd75);
        check("single_func", 64'(alu_func), 64'(c_func_add));
        @(posedge clk); #1;
        check("single_valid_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("single_valid",  64'(out_valid),  64'd1);
        check("single_result", 64'(out_result), 64'd175);
        check("single_tag",    64'(out_tag),    64'd3);
        drain();
        check("single_inflight", 64'(inflight), 64'd0);

        // Back-to-back with out_ready high; only 7-7 sets zero.
        out_ready = 1'b1;
        issue(32'd1024, 32'd2048, c_func_add, 4'd1, 32'd3072, 4'b0000);
        issue(32'd7,    32'd7,    c_func_sub, 4'd2, 32'd0,    4'b0110);
        issue(32'd99,   32'd1,    c_func_sub, 4'd3, 32'd98,   4'b0010);
        drain();

        // Negative operand: 9999 - (-999).
        issue(32'd9999, 32'hFFFF_FC19, c_func_sub, 4'd5, 32'd10998, 4'b0000);
        drain();

        // Backpressure: 8 cycles of offers against a stalled output.
        out_ready = 1'b0;
        accepts = 0;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_a = 32'(k); in_b = 32'd10; in_func = c_func_add; in_tag = 4'(k);
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'(k <= 4));
            if (in_ready) begin
                sb.push_back('{res: 32'(k) + 32'd10, flg: 4'b0000, tag: 4'(k)});
                accepts++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepts", 64'(accepts), 64'd4);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("bp_full_valid", 64'(out_valid), 64'd1);
        check("bp_full_ready", 64'(in_ready),  64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_same_cycle_credit", 64'(in_ready), 64'd0);
        @(posedge clk); #2;
        check("bp_credit_back", 64'(in_ready), 64'd1);
        drain();

        // 20 operations with random out_ready across pointer wrap.
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    if (rand_on) out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join_none
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0)
                issue(32'd1000 * 32'(i) + 32'd7, 32'd3 * 32'(i), c_func_add, 4'(i),
                      32'd1003 * 32'(i) + 32'd7, 4'b0000);
            else
                issue(32'd1000 * 32'(i) + 32'd7, 32'd3 * 32'(i), c_func_sub, 4'(i),
                      32'd997 * 32'(i) + 32'd7, 4'b0010);
        end
        rand_on = 1'b0;
        drain();

        // Reset with two operations in flight and two buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(32'(i), 32'(i), c_func_add, 4'(10 + i), 32'(2 * i), 4'b0000);
        end
        check("mid_inflight", 64'(inflight),  64'd2);
        check("mid_buffered", 64'(out_valid), 64'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_async_valid",    64'(out_valid), 64'd0);
        check("rst_async_inflight", 64'(inflight),  64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #2;
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        issue(32'd1, 32'd2, c_func_add, 4'd9, 32'd3, 4'b0000);
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
